updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down counter. Programmable terminal value, wrap or saturate
//  mode, built-in prescaler, sticky overflow flag and terminal-count pulse for
//  cascading stages. Generic count/timebase element for scan and timing logic.
// PARAMETERS
//  WIDTH     8  counter width in bits (>=2)
//  PRESCALE  1  enabled cycles per count step (>=1; 1 = step on every enabled cycle)
// PORTS
//  clk       in   1      sole clock, all state on rising edge
//  clr       in   1      synchronous, active-high reset; clears all state
//  enable    in   1      count enable; gates prescaler and stepping
//  load      in   1      synchronous parallel load of data
//  data      in   WIDTH  load value
//  dir       in   1      0 = count up, 1 = count down
//  limit     in   WIDTH  terminal value (count range 0..limit), sampled every cycle
//  sat_mode  in   1      0 = wrap at bounds, 1 = saturate at bounds
//  q         out  WIDTH  registered count
//  tc        out  1      registered 1-cycle pulse on a step attempted at a bound
//  ovf       out  1      sticky: set by any bound event, cleared by clr or load
//  zero      out  1      q == 0 (decoded from register, no added latency)
// BEHAVIOUR
//  - Clock clk only; clr is synchronous, active-high. Reset: q=0, tc=0, ovf=0, prescaler=0.
//  - Priority per edge: clr > load > step > hold.
//  - load: q <= (data > limit) ? limit : data; prescaler <= 0; tc <= 0; ovf <= 0.
//  - Prescaler pcnt (0..PRESCALE-1) advances only while enable=1 and no clr/load.
//    step = enable & (pcnt == PRESCALE-1); pcnt wraps to 0 on step.
//    enable=0 freezes pcnt (no reset).
//  - Step up (dir=0): if q >= limit -> bound event; wrap: q <= 0, sat: q holds
//    (if q > limit, q <= limit). Else q <= q+1.
//  - Step down (dir=1): if q == 0 -> bound event; wrap: q <= limit, sat: q holds 0.
//    Else if q > limit, q <= limit. Else q <= q-1.
//  - Bound event: tc=1 on the same edge q updates, for exactly one cycle.
//    In sat mode, tc pulses on every step while held at the bound. ovf <= 1.
//  - No step: tc <= 0. ovf holds.
//  - dir, sat_mode and limit may change on any cycle. They take effect on the
//    next step; no glitch state.
//  - limit=0: q stays 0; every step is a bound event.
//  - All arithmetic is modulo 2^WIDTH. Compare q vs limit unsigned.
//  - clr mid-prescale discards the partial prescale count.
// STRUCTURE
//  - counter_pkg: DIR_UP/DIR_DOWN, MODE_WRAP/MODE_SAT constants; clog2 helper
//    for prescaler width.
//  - Sub-module prescale_tick (PRESCALE param; clk, clr, enable, restart -> step).
//    restart = load. If PRESCALE == 1, it is a passthrough: step = enable.
//  - Top level: step/next-q mux, tc/ovf registers, zero decode.
// TESTING
//  1. W=8, P=1, limit=255, up, wrap, from clr, 256 enabled cycles
//     -> q=255 then 0; tc high exactly 1 cycle; ovf=1.
//  2. limit=9, down, wrap, q=0, 1 step -> q=9, tc=1. Next step -> q=8, tc=0.
//  3. limit=5, up, sat, load 3, 5 steps -> q=3,4,5,5,5; tc on last two steps.
//  4. P=4, up, enable 12 cycles, then low 3, then high 4 -> q=3, hold 3, then q=4.
//  5. load data=200 with limit=100 -> q=100, ovf=0. clr+load same cycle -> q=0.
//  6. Mid-count q=7, pcnt=2 (P=4): assert clr -> q=0, tc=0, ovf=0. The next step
//     needs 4 enabled cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the up/down modulo counter
package counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Smallest r with 2**r >= v; used to size the prescaler register.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prescale_tick.sv
// rtl/prescale_tick.sv - enable-gated prescaler producing one step per PRESCALE enabled cycles
//
// Purpose: counts enabled cycles 0..PRESCALE-1 and asserts step on the last one.
//          With PRESCALE == 1 the counter never leaves 0, so step == enable.
// Ports:
//   clk     in  clock, rising edge
//   clr     in  synchronous active-high reset of the partial count
//   enable  in  advances the count; low freezes it
//   restart in  discards the partial count (driven by the parallel load)
//   step    out one-cycle step strobe
module prescale_tick
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic enable,
    input  logic restart,
    output logic step
);

    localparam int PCNT_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] r_pcnt;
    logic              w_last;

    assign w_last = (r_pcnt == PCNT_LAST);
    // clr/restart win over stepping at the top level too; masking here keeps
    // the strobe meaningful on its own.
    assign step   = enable & w_last & ~clr & ~restart;

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            r_pcnt <= '0;
        end else if (enable) begin
            r_pcnt <= w_last ? '0 : r_pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down counter with terminal value, wrap/saturate, prescaler and flags
//
// Purpose: generic count/timebase element. Counts over 0..limit in either
//          direction, wrapping or saturating at the bounds.
// Ports:
//   clk       in  clock, rising edge
//   clr       in  synchronous active-high reset of all state
//   enable    in  count enable (gates prescaler and stepping)
//   load      in  parallel load of data (clipped to limit)
//   data      in  load value
//   dir       in  0 = up, 1 = down
//   limit     in  terminal value
//   sat_mode  in  0 = wrap, 1 = saturate
//   q         out registered count
//   tc        out one-cycle pulse on a step attempted at a bound
//   ovf       out sticky bound flag, cleared by clr or load
//   zero      out q == 0
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;

    logic             w_step;
    logic             w_bound;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_load_q;
    dir_e             w_dir;
    mode_e            w_mode;

    assign w_dir  = dir_e'(dir);
    assign w_mode = mode_e'(sat_mode);

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk     (clk),
        .clr     (clr),
        .enable  (enable),
        .restart (load),
        .step    (w_step)
    );

    assign w_load_q = (data > limit) ? limit : data;

    always_comb begin
        w_bound  = 1'b0;
        w_next_q = r_q;
        if (w_dir == DIR_UP) begin
            if (r_q >= limit) begin
                w_bound = 1'b1;
                if (w_mode == MODE_WRAP) begin
                    w_next_q = '0;
                end else if (r_q > limit) begin
                    // limit dropped below q: saturate to the new bound
                    w_next_q = limit;
                end
            end else begin
                w_next_q = r_q + WIDTH'(1);
            end
        end else begin
            if (r_q == '0) begin
                w_bound  = 1'b1;
                w_next_q = (w_mode == MODE_WRAP) ? limit : '0;
            end else if (r_q > limit) begin
                w_next_q = limit;
            end else begin
                w_next_q = r_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_step) begin
            r_q   <= w_next_q;
            r_tc  <= w_bound;
            r_ovf <= r_ovf | w_bound;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign ovf  = r_ovf;
    assign zero = (r_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter (P=1 and P=4 instances)
module tb_updown_mod_counter;

    logic       clk;
    logic       clr;
    logic       enable;
    logic       load;
    logic [7:0] data;
    logic       dir;
    logic [7:0] limit;
    logic       sat_mode;

    logic [7:0] q1, q4;
    logic       tc1, tc4, ovf1, ovf4, zero1, zero4;

    int n_checks;
    int n_fail;

    int m_q   [2];
    int m_tc  [2];
    int m_ovf [2];
    int m_pc  [2];

    typedef struct {
        logic clr;
        logic load;
        logic en;
        logic dir;
        logic sat;
        int   lim;
        int   data;
        int   eq;
        int   etc;
        int   eovf;
    } vec_t;

    vec_t tbl[$];

    updown_mod_counter #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk(clk), .clr(clr), .enable(enable), .load(load), .data(data),
        .dir(dir), .limit(limit), .sat_mode(sat_mode),
        .q(q1), .tc(tc1), .ovf(ovf1), .zero(zero1)
    );

    updown_mod_counter #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .clr(clr), .enable(enable), .load(load), .data(data),
        .dir(dir), .limit(limit), .sat_mode(sat_mode),
        .q(q4), .tc(tc4), .ovf(ovf4), .zero(zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: plain integer arithmetic over the counter's rules.
    task automatic model_edge(input int i);
        int p;
        int lim;
        int stepping;
        p   = (i == 0) ? 1 : 4;
        lim = int'(limit);
        if (clr) begin
            m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_pc[i] = 0;
        end else if (load) begin
            m_q[i]  = (int'(data) > lim) ? lim : int'(data);
            m_tc[i] = 0; m_ovf[i] = 0; m_pc[i] = 0;
        end else begin
            stepping = 0;
            if (enable) begin
                m_pc[i] = m_pc[i] + 1;
                if (m_pc[i] == p) begin
                    m_pc[i]  = 0;
                    stepping = 1;
                end
            end
            m_tc[i] = 0;
            if (stepping != 0) begin
                if (dir == 1'b0) begin
                    if (m_q[i] >= lim) begin
                        m_tc[i] = 1;
                        m_q[i]  = sat_mode ? ((m_q[i] < lim) ? m_q[i] : lim) : 0;
                    end else begin
                        m_q[i] = m_q[i] + 1;
                    end
                end else begin
                    if (m_q[i] == 0) begin
                        m_tc[i] = 1;
                        m_q[i]  = sat_mode ? 0 : lim;
                    end else if (m_q[i] > lim) begin
                        m_q[i] = lim;
                    end else begin
                        m_q[i] = m_q[i] - 1;
                    end
                end
                if (m_tc[i] != 0) m_ovf[i] = 1;
            end
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        chk("model_q_p1",    int'(q1),    m_q[0]);
        chk("model_tc_p1",   int'(tc1),   m_tc[0]);
        chk("model_ovf_p1",  int'(ovf1),  m_ovf[0]);
        chk("model_zero_p1", int'(zero1), (m_q[0] == 0) ? 1 : 0);
        chk("model_q_p4",    int'(q4),    m_q[1]);
        chk("model_tc_p4",   int'(tc4),   m_tc[1]);
        chk("model_ovf_p4",  int'(ovf4),  m_ovf[1]);
        chk("model_zero_p4", int'(zero4), (m_q[1] == 0) ? 1 : 0);
    endtask

    task automatic set_in(input logic c, input logic l, input logic e, input logic d,
                          input logic s, input int lim, input int dat);
        clr = c; load = l; enable = e; dir = d; sat_mode = s;
        limit = 8'(lim); data = 8'(dat);
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic e, input logic d,
                                input logic s, input int lim, input int dat,
                                input int eq, input int etc, input int eovf);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.dir = d; v.sat = s;
        v.lim = lim; v.data = dat; v.eq = eq; v.etc = etc; v.eovf = eovf;
        return v;
    endfunction

    initial begin
        int tc_count;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_pc[i] = 0;
        end
        set_in(1, 0, 0, 0, 0, 255, 0);
        tick();
        tick();

        //            clr load en dir sat lim dat   q  tc ovf
        tbl.push_back(mk(1, 0, 0, 0, 0,   9,   0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0,   9,   0,   9, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0,   9,   0,   8, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1,   5,   3,   3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1,   5,   0,   4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1,   5,   0,   5, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1,   5,   0,   5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1,   5,   0,   5, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1,   5,   0,   5, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 100, 200, 100, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0,  50,   0,  50, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,  50,   7,   0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,   0,   0,   0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1,   0,   0,   0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0,   3,   5,   3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,   2,   0,   0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0,   2,   0,   2, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1,   2,   0,   2, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1,   1,   0,   1, 1, 1));

        foreach (tbl[k]) begin
            set_in(tbl[k].clr, tbl[k].load, tbl[k].en, tbl[k].dir, tbl[k].sat,
                   tbl[k].lim, tbl[k].data);
            tick();
            chk($sformatf("vec%0d_q", k),   int'(q1),   tbl[k].eq);
            chk($sformatf("vec%0d_tc", k),  int'(tc1),  tbl[k].etc);
            chk($sformatf("vec%0d_ovf", k), int'(ovf1), tbl[k].eovf);
        end

        // Full-range wrap from reset on the P=1 instance.
        set_in(1, 0, 0, 0, 0, 255, 0);
        tick();
        chk("wrap_reset_q", int'(q1), 0);
        chk("wrap_reset_zero", int'(zero1), 1);
        set_in(0, 0, 1, 0, 0, 255, 0);
        tc_count = 0;
        for (int c = 1; c <= 256; c++) begin
            tick();
            if (tc1) tc_count++;
            if (c == 255) chk("wrap_q255", int'(q1), 255);
        end
        chk("wrap_q0", int'(q1), 0);
        chk("wrap_tc_last", int'(tc1), 1);
        chk("wrap_tc_count", tc_count, 1);
        chk("wrap_ovf", int'(ovf1), 1);

        // P=4: 12 enabled cycles, 3 disabled, 4 enabled.
        set_in(1, 0, 0, 0, 0, 255, 0);
        tick();
        set_in(0, 0, 1, 0, 0, 255, 0);
        for (int c = 0; c < 12; c++) tick();
        chk("p4_after12", int'(q4), 3);
        enable = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("p4_hold", int'(q4), 3);
        enable = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("p4_partial", int'(q4), 3);
        tick();
        chk("p4_after4", int'(q4), 4);

        // P=4: clr mid-prescale discards the partial count.
        set_in(1, 0, 0, 0, 0, 255, 0);
        tick();
        set_in(0, 0, 1, 0, 0, 255, 0);
        for (int c = 0; c < 30; c++) tick();
        chk("p4_mid_q7", int'(q4), 7);
        set_in(1, 0, 1, 0, 0, 255, 0);
        tick();
        chk("p4_clr_q", int'(q4), 0);
        chk("p4_clr_tc", int'(tc4), 0);
        chk("p4_clr_ovf", int'(ovf4), 0);
        clr = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("p4_clr_partial", int'(q4), 0);
        tick();
        chk("p4_clr_full", int'(q4), 1);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            clr      = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 5);
            enable   = ($urandom_range(0, 99) < 80);
            dir      = 1'($urandom_range(0, 1));
            sat_mode = 1'($urandom_range(0, 1));
            data     = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 10) begin
                limit = 8'($urandom_range(0, 255));
            end else if (c % 200 == 0) begin
                limit = 8'($urandom_range(0, 12));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
